// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : Oversampling UART receiver (start, W data bits LSB first,
//            optional parity, one stop bit). Accepted bytes are stored in a
//            2 x 4 matrix addressed by a wrapping 3-bit write pointer, with a
//            saturating frame count and a sticky overflow flag.
// Ports    : clk      rising-edge clock
//            rst      asynchronous active-low reset
//            rx       serial line, idle high, asynchronous to clk
//            row/col  matrix read address (col declared [0:1])
//            clr      synchronous clear of write pointer, count and overflow
//            r_cell   combinational read of matrix[row][col]
//            data     last accepted byte
//            valid    one-cycle pulse, frame accepted
//            par_err  one-cycle pulse with valid on parity mismatch
//            frm_err  one-cycle pulse, stop bit sampled low
//            busy     receiver not in IDLE
//            count    stored frames since clear, saturating at 8
//            ovf      sticky, a frame was written while count == 8
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int W   = 8,
    parameter int DIV = 3,
    parameter int PAR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    input  logic         row,
    input  logic [0:1]   col,
    input  logic         clr,
    output logic [W-1:0] r_cell,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         par_err,
    output logic         frm_err,
    output logic         busy,
    output logic [3:0]   count,
    output logic         ovf
);

    localparam int CKW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CKW-1:0] c_CK_LAST = CKW'(DIV - 1);
    localparam logic [CKW-1:0] c_CK_MID  = CKW'(DIV / 2);
    localparam logic [BIW-1:0] c_BI_LAST = BIW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // Synchronizer and arming
    logic         r_rx_meta;
    logic         r_rx_sync;
    logic [1:0]   r_fill;
    logic         r_armed;
    logic         w_rx;

    // Frame FSM
    state_t       r_state;
    state_t       w_state_nx;
    logic [CKW-1:0] r_ck;
    logic [CKW-1:0] w_ck_nx;
    logic [BIW-1:0] r_bi;
    logic [BIW-1:0] w_bi_nx;
    logic [W-1:0] r_shift;
    logic [W-1:0] w_shift_nx;
    logic         r_par_bad;
    logic         w_par_bad_nx;
    logic         w_par_exp;
    logic         w_ck_last;
    logic         w_accept;
    logic         w_reject;

    // Storage and outputs
    logic [W-1:0] r_mem [0:7];
    logic [2:0]   r_ptr;
    logic [3:0]   r_count;
    logic         r_ovf;
    logic [W-1:0] r_data;
    logic         r_valid;
    logic         r_par_err;
    logic         r_frm_err;

    assign w_rx = r_rx_sync;

    // r_fill marks when both synchronizer stages hold real line samples
    // rather than their reset value. Until the line has then been seen
    // high, a frame that was in flight across reset is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_fill    <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_fill    <= {r_fill[0], 1'b1};
            if (r_fill[1] && r_rx_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ck      <= '0;
            r_bi      <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_ck      <= w_ck_nx;
            r_bi      <= w_bi_nx;
            r_shift   <= w_shift_nx;
            r_par_bad <= w_par_bad_nx;
        end
    end

    assign w_ck_last = (r_ck == c_CK_LAST);
    assign w_par_exp = (PAR == 2) ? ~(^r_shift) : (^r_shift);

    always_comb begin
        w_state_nx   = r_state;
        w_ck_nx      = r_ck + CKW'(1);
        w_bi_nx      = r_bi;
        w_shift_nx   = r_shift;
        w_par_bad_nx = r_par_bad;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ck_nx = '0;
                if (r_armed && !w_rx) begin
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                // Mid-bit recheck rejects short glitches without any flag.
                if (r_ck == c_CK_MID) begin
                    w_ck_nx      = '0;
                    w_bi_nx      = '0;
                    w_par_bad_nx = 1'b0;
                    w_state_nx   = w_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_ck_last) begin
                    w_ck_nx    = '0;
                    // LSB first: shift right, new bit enters at the MSB.
                    w_shift_nx = (r_shift >> 1) | (W'(w_rx) << (W - 1));
                    if (r_bi == c_BI_LAST) begin
                        w_state_nx = (PAR != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bi_nx = r_bi + BIW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_ck_last) begin
                    w_ck_nx      = '0;
                    w_par_bad_nx = (w_rx != w_par_exp);
                    w_state_nx   = S_STOP;
                end
            end
            S_STOP: begin
                if (w_ck_last) begin
                    w_ck_nx = '0;
                    if (w_rx) begin
                        w_accept   = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_reject   = 1'b1;
                        w_state_nx = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_ck_nx = '0;
                if (w_rx) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_ck_nx    = '0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Result registers: the stop-sample edge publishes the frame, so the
    // pulses appear on the cycle after the stop sample. A concurrent clr
    // wins over the matrix write but still lets valid/data through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
            r_ptr     <= 3'd0;
            r_count   <= 4'd0;
            r_ovf     <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_valid   <= w_accept;
            r_par_err <= w_accept & r_par_bad;
            r_frm_err <= w_reject;
            if (w_accept) begin
                r_data <= r_shift;
            end
            if (clr) begin
                r_ptr   <= 3'd0;
                r_count <= 4'd0;
                r_ovf   <= 1'b0;
            end else if (w_accept) begin
                r_mem[r_ptr] <= r_shift;
                r_ptr        <= r_ptr + 3'd1;
                if (r_count == 4'd8) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + 4'd1;
                end
            end
        end
    end

    // {row, col} is the row-major cell index; col[0] is the column MSB.
    assign r_cell  = r_mem[{row, col}];
    assign data    = r_data;
    assign valid   = r_valid;
    assign par_err = r_par_err;
    assign frm_err = r_frm_err;
    assign busy    = (r_state != S_IDLE);
    assign count   = r_count;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire
